// File: rtl/array_ext_pkg.sv
// Shared parameters and types for the cache-array SRAM front-end.
package array_ext_pkg;

  localparam int unsigned SETS   = 128;
  localparam int unsigned ADDR_W = $clog2(SETS);
  localparam int unsigned WAYS   = 4;
  localparam int unsigned WAY_W  = 21;
  localparam int unsigned ROW_W  = WAYS * WAY_W;

  // INIT clears the array; RUN arbitrates client requests.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage : array_ext_pkg

// File: rtl/array_ext_init_seq.sv
// Clear-sweep sequencer: walks every set once after reset or flush, then
// hands the array over to RUN. init_cnt wraps naturally to 0 on leaving INIT.
module array_ext_init_seq
  import array_ext_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  output state_e            state,
  output logic [ADDR_W-1:0] init_cnt,
  output logic              init_done
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic              init_done_q, init_done_d;

  // Next-state: advance the sweep, restart it on flush, leave INIT after the last set.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    unique case (state_q)
      INIT: begin
        if (flush) begin
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + ADDR_W'(1);
          if (init_cnt_q == ADDR_W'(SETS - 1)) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (flush) begin
          state_d    = INIT;
          init_cnt_d = '0;
        end
      end
      default: begin
        state_d    = INIT;
        init_cnt_d = '0;
      end
    endcase
    init_done_d = (state_d == RUN);
  end

  // State, sweep counter and done flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
    end
  end

  assign state     = state_q;
  assign init_cnt  = init_cnt_q;
  assign init_done = init_done_q;

endmodule : array_ext_init_seq

// File: rtl/array_ext_frontend.sv
// Front-end for the 128x84 single-port cache-array macro: clears all sets after
// reset/flush, then arbitrates one write and one read port (write wins) onto the
// macro and returns read data one cycle after acceptance.
// Optional build macro ARRAY_RDATA_HOLD_EN: keep the last read row on r_resp_data
// between responses.
module array_ext_frontend
  import array_ext_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  output logic              init_done,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [ADDR_W-1:0] w_set,
  input  logic [ROW_W-1:0]  w_data,
  input  logic [WAYS-1:0]   w_waymask,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [ADDR_W-1:0] r_set,
  output logic              r_resp_valid,
  output logic [ROW_W-1:0]  r_resp_data,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ROW_W-1:0]  sram_wdata,
  output logic [WAYS-1:0]   sram_wmask,
  input  logic [ROW_W-1:0]  sram_rdata
);

  state_e            state;
  logic [ADDR_W-1:0] init_cnt;
  logic              w_fire;
  logic              r_fire;
  logic              r_resp_valid_q, r_resp_valid_d;

  array_ext_init_seq u_init_seq (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (flush),
    .state     (state),
    .init_cnt  (init_cnt),
    .init_done (init_done)
  );

  // Handshake: nothing is accepted during the sweep or in a flush cycle; write beats read.
  always_comb begin
    w_ready = 1'b0;
    r_ready = 1'b0;
    if ((state == RUN) && !flush) begin
      w_ready = 1'b1;
      r_ready = !w_valid;
    end
    w_fire = w_valid & w_ready;
    r_fire = r_valid & r_ready;
  end

  // Macro port mux: clear-sweep write, client write, client read, or idle.
  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    sram_wmask = '0;
    if (state == INIT) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = init_cnt;
      sram_wmask = '1;
    end else if (w_fire) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = w_set;
      sram_wdata = w_data;
      sram_wmask = w_waymask;
    end else if (r_fire) begin
      sram_en    = 1'b1;
      sram_addr  = r_set;
    end
  end

  // Response valid tracks the macro's one-cycle read latency.
  always_comb begin
    r_resp_valid_d = r_fire;
  end

  // Response-valid register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_resp_valid_q <= 1'b0;
    end else begin
      r_resp_valid_q <= r_resp_valid_d;
    end
  end

  assign r_resp_valid = r_resp_valid_q;

`ifdef ARRAY_RDATA_HOLD_EN
  logic [ROW_W-1:0] hold_q, hold_d;

  // Hold the last returned row; a flush starts a fresh sweep so the stale row is dropped.
  always_comb begin
    hold_d = hold_q;
    if (flush) begin
      hold_d = '0;
    end else if (r_resp_valid_q) begin
      hold_d = sram_rdata;
    end
    r_resp_data = r_resp_valid_q ? sram_rdata : hold_q;
  end

  // Hold register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  // Macro read data passes straight through; meaningful only with r_resp_valid.
  always_comb begin
    r_resp_data = sram_rdata;
  end
`endif

endmodule : array_ext_frontend

// File: tb/tb_array_ext_frontend.sv
// Directed bench for array_ext_frontend with a behavioural single-port macro model.
module tb_array_ext_frontend;
  import array_ext_pkg::*;

  logic              clock;
  logic              reset_n;
  logic              flush;
  logic              init_done;
  logic              w_valid;
  logic              w_ready;
  logic [ADDR_W-1:0] w_set;
  logic [ROW_W-1:0]  w_data;
  logic [WAYS-1:0]   w_waymask;
  logic              r_valid;
  logic              r_ready;
  logic [ADDR_W-1:0] r_set;
  logic              r_resp_valid;
  logic [ROW_W-1:0]  r_resp_data;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_en;
  logic              sram_wmode;
  logic [ROW_W-1:0]  sram_wdata;
  logic [WAYS-1:0]   sram_wmask;
  logic [ROW_W-1:0]  sram_rdata;

  int checks;
  int failures;

  logic [ROW_W-1:0] mem [SETS];

  logic [ROW_W-1:0] d2, exp2, w3, da, db, way02;

  array_ext_frontend dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .flush        (flush),
    .init_done    (init_done),
    .w_valid      (w_valid),
    .w_ready      (w_ready),
    .w_set        (w_set),
    .w_data       (w_data),
    .w_waymask    (w_waymask),
    .r_valid      (r_valid),
    .r_ready      (r_ready),
    .r_set        (r_set),
    .r_resp_valid (r_resp_valid),
    .r_resp_data  (r_resp_data),
    .sram_addr    (sram_addr),
    .sram_en      (sram_en),
    .sram_wmode   (sram_wmode),
    .sram_wdata   (sram_wdata),
    .sram_wmask   (sram_wmask),
    .sram_rdata   (sram_rdata)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Macro model: masked per-way write, 1-cycle read; garbage on non-read cycles.
  always @(posedge clock) begin
    if (sram_en && sram_wmode) begin
      for (int k = 0; k < WAYS; k++) begin
        if (sram_wmask[k]) mem[sram_addr][k*WAY_W +: WAY_W] <= sram_wdata[k*WAY_W +: WAY_W];
      end
      sram_rdata <= {ROW_W{1'b1}};
    end else if (sram_en) begin
      sram_rdata <= mem[sram_addr];
    end else begin
      sram_rdata <= {ROW_W{1'b1}};
    end
  end

  task automatic chk(input string tag, input logic [ROW_W-1:0] got, input logic [ROW_W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset_n   = 1'b0;
    flush     = 1'b0;
    w_valid   = 1'b0;
    w_set     = '0;
    w_data    = '0;
    w_waymask = '0;
    r_valid   = 1'b0;
    r_set     = '0;
    for (int i = 0; i < SETS; i++) mem[i] = ROW_W'({$urandom, $urandom, $urandom});
    d2    = 84'h1_2345_6789_ABCD_EF01_2345;
    way02 = {21'd0, {21{1'b1}}, 21'd0, {21{1'b1}}};
    exp2  = d2 & way02;
    w3    = 84'hA_5A5A_5A5A_5A5A_5A5A_5A5A;
    da    = 84'h0_1111_2222_3333_4444_5555;
    db    = 84'hF_EDCB_A987_6543_210F_EDCB;

    // Reset values
    #12;
    chk("rst_init_done", ROW_W'(init_done), '0);
    chk("rst_resp_valid", ROW_W'(r_resp_valid), '0);
    chk("rst_w_ready", ROW_W'(w_ready), '0);
    chk("rst_r_ready", ROW_W'(r_ready), '0);

    // 1: sweep of 128 clearing writes, requests refused throughout
    w_valid = 1'b1; w_set = 7'd3; r_valid = 1'b1; r_set = 7'd4;
    #10 reset_n = 1'b1;
    #1;
    chk("sweep_wmask", ROW_W'(sram_wmask), ROW_W'(4'hF));
    chk("sweep_wdata", sram_wdata, '0);
    for (int k = 0; k < 128; k++) begin
      chk("sweep_addr", ROW_W'(sram_addr), ROW_W'(k));
      chk("sweep_en_wmode", ROW_W'({sram_en, sram_wmode}), ROW_W'(2'b11));
      chk("sweep_w_ready", ROW_W'(w_ready), '0);
      chk("sweep_r_ready", ROW_W'(r_ready), '0);
      chk("sweep_init_done", ROW_W'(init_done), '0);
      if (k == 127) begin
        w_valid = 1'b0;
        r_valid = 1'b0;
      end
      tick();
    end
    chk("c129_init_done", ROW_W'(init_done), ROW_W'(1));
    chk("c129_idle_en", ROW_W'(sram_en), '0);

    // 2: masked write to set 5 then read back
    w_valid = 1'b1; w_set = 7'd5; w_data = d2; w_waymask = 4'b0101;
    #1;
    chk("wr5_ready", ROW_W'(w_ready), ROW_W'(1));
    chk("wr5_port", ROW_W'({sram_en, sram_wmode, sram_addr, sram_wmask}), ROW_W'({2'b11, 7'd5, 4'b0101}));
    chk("wr5_wdata", sram_wdata, d2);
    tick();
    w_valid = 1'b0; r_valid = 1'b1; r_set = 7'd5;
    #1;
    chk("rd5_ready", ROW_W'(r_ready), ROW_W'(1));
    chk("rd5_port", ROW_W'({sram_en, sram_wmode, sram_addr}), ROW_W'({2'b10, 7'd5}));
    tick();
    r_valid = 1'b0;
    chk("rd5_resp_valid", ROW_W'(r_resp_valid), ROW_W'(1));
    chk("rd5_resp_data", r_resp_data, exp2);
    tick();
    chk("rd5_resp_drop", ROW_W'(r_resp_valid), '0);
`ifdef ARRAY_RDATA_HOLD_EN
    chk("rd5_hold", r_resp_data, exp2);
`endif

    // zero-mask write to set 9 occupies the port but changes nothing
    w_valid = 1'b1; w_set = 7'd9; w_data = {ROW_W{1'b1}}; w_waymask = 4'b0000;
    #1;
    chk("wr9_m0_port", ROW_W'({w_ready, sram_en, sram_wmode, sram_wmask}), ROW_W'({3'b111, 4'b0000}));
    tick();

    // 3: write/read conflict, write wins
    w_set = 7'd3; w_data = w3; w_waymask = 4'hF; r_valid = 1'b1; r_set = 7'd9;
    #1;
    chk("cf_ready", ROW_W'({w_ready, r_ready}), ROW_W'(2'b10));
    chk("cf_wr_addr", ROW_W'({sram_wmode, sram_addr}), ROW_W'({1'b1, 7'd3}));
    tick();
    w_valid = 1'b0;
    #1;
    chk("cf_rd_issue", ROW_W'({r_ready, sram_wmode, sram_addr}), ROW_W'({2'b10, 7'd9}));
    chk("cf_no_resp", ROW_W'(r_resp_valid), '0);
    tick();
    r_valid = 1'b0;
    chk("cf_resp_valid", ROW_W'(r_resp_valid), ROW_W'(1));
    chk("cf_resp_data9", r_resp_data, '0);

    // 4: back-to-back reads of sets 1,2,3
    w_valid = 1'b1; w_set = 7'd1; w_data = da; w_waymask = 4'hF;
    tick();
    w_set = 7'd2; w_data = db;
    tick();
    w_valid = 1'b0; r_valid = 1'b1; r_set = 7'd1;
    tick();
    r_set = 7'd2;
    chk("b2b_v1", ROW_W'(r_resp_valid), ROW_W'(1));
    chk("b2b_d1", r_resp_data, da);
    tick();
    r_set = 7'd3;
    chk("b2b_v2", ROW_W'(r_resp_valid), ROW_W'(1));
    chk("b2b_d2", r_resp_data, db);
    tick();
    r_valid = 1'b0;
    chk("b2b_v3", ROW_W'(r_resp_valid), ROW_W'(1));
    chk("b2b_d3", r_resp_data, w3);
    tick();
    chk("b2b_end", ROW_W'(r_resp_valid), '0);

    // 5: flush right after an accepted read
    r_valid = 1'b1; r_set = 7'd5;
    #1;
    chk("fl_rd_ready", ROW_W'(r_ready), ROW_W'(1));
    tick();
    r_valid = 1'b0; flush = 1'b1; w_valid = 1'b1; w_set = 7'd7; w_data = da;
    #1;
    chk("fl_no_accept", ROW_W'({w_ready, r_ready, sram_en}), '0);
    chk("fl_resp_valid", ROW_W'(r_resp_valid), ROW_W'(1));
    chk("fl_resp_data", r_resp_data, exp2);
    tick();
    flush = 1'b0; w_valid = 1'b0;
    chk("fl_init_done", ROW_W'(init_done), '0);
    chk("fl_sweep0", ROW_W'({sram_en, sram_wmode, sram_addr}), ROW_W'({2'b11, 7'd0}));
`ifdef ARRAY_RDATA_HOLD_EN
    chk("fl_hold_clr", r_resp_data, '0);
`endif
    for (int k = 1; k < 128; k++) tick();
    chk("fl_sweep127", ROW_W'(sram_addr), ROW_W'(127));
    chk("fl_sweep127_busy", ROW_W'(init_done), '0);
    tick();
    chk("fl_done", ROW_W'(init_done), ROW_W'(1));
    r_valid = 1'b1; r_set = 7'd5;
    tick();
    r_valid = 1'b0;
    chk("fl_rd5_valid", ROW_W'(r_resp_valid), ROW_W'(1));
    chk("fl_rd5_cleared", r_resp_data, '0);

    // 6: reset mid-sweep, then flush during INIT
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int k = 1; k <= 60; k++) tick();
    chk("mr_addr60", ROW_W'(sram_addr), ROW_W'(60));
    #2 reset_n = 1'b0;
    #1;
    chk("mr_rst_addr", ROW_W'(sram_addr), '0);
    chk("mr_rst_flags", ROW_W'({init_done, r_resp_valid, w_ready, r_ready}), '0);
    #2 reset_n = 1'b1;
    tick();
    chk("mr_restart1", ROW_W'(sram_addr), ROW_W'(1));
    for (int k = 2; k <= 10; k++) tick();
    chk("mr_addr10", ROW_W'(sram_addr), ROW_W'(10));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("if_restart0", ROW_W'(sram_addr), '0);
    for (int k = 1; k < 128; k++) tick();
    chk("if_addr127", ROW_W'(sram_addr), ROW_W'(127));
    tick();
    chk("if_done", ROW_W'(init_done), ROW_W'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_array_ext_frontend
